// File: rtl/stone_drawer_if.sv
// Bus between the stone drawer and its environment: frame request,
// stone-RAM read port and the pixel-plot stream.
interface stone_drawer_if;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, quantity, data,
        input  draw_stone_flag, draw_index, x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, quantity, data,
        output draw_stone_flag, draw_index, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/stone_drawer.sv
// Scans the stone records for one frame and emits a STONE_SIZE x STONE_SIZE
// square of pixels for every visible stone, clipped to a 320x240 screen.
module stone_drawer #(
    parameter int         STONE_SIZE  = 16,
    parameter logic [2:0] COL_STONE   = 3'b111,
    parameter logic [2:0] COL_GOLD    = 3'b110,
    parameter logic [2:0] COL_DIAMOND = 3'b011
) (
    input  logic          clock,
    input  logic          reset,
    stone_drawer_if.slave bus
);
    localparam int            CW   = (STONE_SIZE > 1) ? $clog2(STONE_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(STONE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_PIXEL, S_NEXT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    i_q, i_d;
    logic [3:0]    qty_q, qty_d;
    logic [8:0]    rec_x_q, rec_x_d;
    logic [7:0]    rec_y_q, rec_y_d;
    logic [1:0]    rec_t_q, rec_t_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          flag_q, flag_d;
    logic [3:0]    draw_index_q, draw_index_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          emit;
    logic [8:0]    src_x;
    logic [7:0]    src_y;
    logic [1:0]    src_t;
    logic [9:0]    px;
    logic [9:0]    py;
    logic          unused_bits;

    assign unused_bits = ^{bus.data[22:19], bus.data[10:4], bus.data[0]};

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        qty_d        = qty_q;
        rec_x_d      = rec_x_q;
        rec_y_d      = rec_y_q;
        rec_t_d      = rec_t_q;
        col_d        = col_q;
        row_d        = row_q;
        flag_d       = flag_q;
        draw_index_d = draw_index_q;
        x_d          = '0;
        y_d          = '0;
        colour_d     = '0;
        plot_d       = 1'b0;
        emit         = 1'b0;

        // The first pixel is emitted on the LATCH transition, before the
        // record registers hold the new stone, so read the fields from data.
        if (state_q == S_LATCH) begin
            src_x = bus.data[31:23];
            src_y = bus.data[18:11];
            src_t = bus.data[3:2];
        end else begin
            src_x = rec_x_q;
            src_y = rec_y_q;
            src_t = rec_t_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    qty_d = bus.quantity;
                    i_d   = '0;
                    if (bus.quantity == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_ADDR;
                        draw_index_d = '0;
                        flag_d       = 1'b1;
                    end
                end
            end
            S_ADDR:  state_d = S_WAIT;
            S_WAIT:  state_d = S_LATCH;
            S_LATCH: begin
                rec_x_d = bus.data[31:23];
                rec_y_d = bus.data[18:11];
                rec_t_d = bus.data[3:2];
                if (bus.data[1]) begin
                    state_d = S_PIXEL;
                    col_d   = '0;
                    row_d   = '0;
                    emit    = 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_PIXEL: begin
                if (col_q == LAST && row_q == LAST) begin
                    state_d = S_NEXT;
                end else begin
                    if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    emit = 1'b1;
                end
            end
            S_NEXT: begin
                if (i_q == 4'(qty_q - 4'd1)) begin
                    state_d = S_DONE;
                    flag_d  = 1'b0;
                end else begin
                    i_d          = i_q + 4'd1;
                    draw_index_d = i_q + 4'd1;
                    state_d      = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        px = {1'b0, src_x} + 10'(col_d);
        py = {2'b0, src_y} + 10'(row_d);
        if (emit) begin
            x_d = px;
            y_d = py;
            case (src_t)
                2'b00:   colour_d = COL_STONE;
                2'b01:   colour_d = COL_GOLD;
                default: colour_d = COL_DIAMOND;
            endcase
            plot_d = (px <= 10'd319) && (py <= 10'd239);
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            qty_q        <= '0;
            rec_x_q      <= '0;
            rec_y_q      <= '0;
            rec_t_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            flag_q       <= 1'b0;
            draw_index_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            qty_q        <= qty_d;
            rec_x_q      <= rec_x_d;
            rec_y_q      <= rec_y_d;
            rec_t_q      <= rec_t_d;
            col_q        <= col_d;
            row_q        <= row_d;
            flag_q       <= flag_d;
            draw_index_q <= draw_index_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.draw_stone_flag = flag_q;
    assign bus.draw_index      = draw_index_q;
    assign bus.x               = x_q;
    assign bus.y               = y_q;
    assign bus.colour          = colour_q;
    assign bus.plot            = plot_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_stone_drawer.sv
// Directed bench for stone_drawer: a registered-read stone RAM model and a
// negedge monitor that tallies plotted pixels, flag cycles and done pulses.
module tb_stone_drawer;
    logic clock = 1'b0;
    logic reset;

    stone_drawer_if bus ();

    stone_drawer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [0:15];
    always @(posedge clock) bus.data <= ram[bus.draw_index];

    int checks = 0;
    int errors = 0;

    int plot_cnt, flag_cnt, done_cnt, box_cnt, clip_cnt;
    logic [9:0] first_x, first_y, last_x, last_y;
    logic [2:0] first_col, last_col;
    int idx_seq [$];

    always @(negedge clock) begin
        if (bus.plot) begin
            if (plot_cnt == 0) begin
                first_x   = bus.x;
                first_y   = bus.y;
                first_col = bus.colour;
            end
            last_x   = bus.x;
            last_y   = bus.y;
            last_col = bus.colour;
            plot_cnt++;
            if (bus.x >= 10'd200 && bus.x <= 10'd215 && bus.y >= 10'd100 && bus.y <= 10'd115)
                box_cnt++;
            if (bus.x > 10'd319 || bus.y > 10'd239)
                clip_cnt++;
        end
        if (bus.draw_stone_flag) begin
            flag_cnt++;
            if (idx_seq.size() == 0 || idx_seq[$] != int'(bus.draw_index))
                idx_seq.push_back(int'(bus.draw_index));
        end
        if (bus.done) done_cnt++;
    end

    function automatic logic [31:0] rec(input int xx, input int yy, input logic [1:0] t,
                                        input logic vis, input logic mov);
        logic [8:0] xf;
        logic [7:0] yf;
        xf = 9'(xx);
        yf = 8'(yy);
        return {xf, 4'b0, yf, 7'b0, t, vis, mov};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic clear_mon();
        plot_cnt = 0; flag_cnt = 0; done_cnt = 0; box_cnt = 0; clip_cnt = 0;
        first_x = '0; first_y = '0; last_x = '0; last_y = '0;
        first_col = '0; last_col = '0;
        idx_seq.delete();
    endtask

    // Cycle 1 is the cycle in which start is high; returns the cycle number
    // in which done is observed (or the budget if it never arrives).
    task automatic run_frame(input logic [3:0] q, input int budget, output int cyc);
        clear_mon();
        @(negedge clock);
        bus.quantity = q;
        bus.start    = 1'b1;
        cyc = 1;
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 2;
        while (!bus.done && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        @(posedge clock);
        #1;
        $display("frame quantity=%0d done_cycle=%0d plots=%0d flag_cycles=%0d",
                 q, cyc, plot_cnt, flag_cnt);
    endtask

    int cyc;

    initial begin
        for (int k = 0; k < 16; k++) ram[k] = '0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.quantity = '0;
        clear_mon();
        repeat (3) @(negedge clock);
        check("reset_busy",  32'(bus.busy), 0);
        check("reset_plot",  32'(bus.plot), 0);
        check("reset_flag",  32'(bus.draw_stone_flag), 0);
        check("reset_done",  32'(bus.done), 0);
        check("reset_x",     32'(bus.x), 0);
        reset = 1'b0;

        // Empty frame
        run_frame(4'd0, 2000, cyc);
        check("q0_latency", cyc, 2);
        check("q0_plots",   plot_cnt, 0);
        check("q0_flag",    flag_cnt, 0);
        check("q0_done",    done_cnt, 1);

        // One gold stone
        ram[0] = rec(100, 50, 2'b01, 1'b1, 1'b0);
        run_frame(4'd1, 2000, cyc);
        check("q1_latency", cyc, 262);
        check("q1_plots",   plot_cnt, 256);
        check("q1_first_x", 32'(first_x), 100);
        check("q1_first_y", 32'(first_y), 50);
        check("q1_last_x",  32'(last_x), 115);
        check("q1_last_y",  32'(last_y), 65);
        check("q1_colour",  32'(first_col), 32'(3'b110));
        check("q1_flag",    flag_cnt, 260);
        check("q1_idle",    32'(bus.busy), 0);

        // Three stones, middle one hidden, last one moving stone-type
        ram[0] = rec(0, 0, 2'b01, 1'b1, 1'b0);
        ram[1] = rec(200, 100, 2'b11, 1'b0, 1'b0);
        ram[2] = rec(40, 40, 2'b00, 1'b1, 1'b1);
        run_frame(4'd3, 2000, cyc);
        check("q3_latency", cyc, 526);
        check("q3_plots",   plot_cnt, 512);
        check("q3_hidden",  box_cnt, 0);
        check("q3_nidx",    idx_seq.size(), 3);
        if (idx_seq.size() == 3) begin
            check("q3_idx0", idx_seq[0], 0);
            check("q3_idx1", idx_seq[1], 1);
            check("q3_idx2", idx_seq[2], 2);
        end
        check("q3_first_x", 32'(first_x), 0);
        check("q3_first_col", 32'(first_col), 32'(3'b110));
        check("q3_last_x",  32'(last_x), 55);
        check("q3_last_y",  32'(last_y), 55);
        check("q3_last_col", 32'(last_col), 32'(3'b111));

        // Clipped diamond near the bottom-right corner
        ram[0] = rec(310, 230, 2'b10, 1'b1, 1'b0);
        run_frame(4'd1, 2000, cyc);
        check("clip_latency", cyc, 262);
        check("clip_plots",   plot_cnt, 100);
        check("clip_outside", clip_cnt, 0);
        check("clip_first_x", 32'(first_x), 310);
        check("clip_first_y", 32'(first_y), 230);
        check("clip_last_x",  32'(last_x), 319);
        check("clip_last_y",  32'(last_y), 239);
        check("clip_colour",  32'(first_col), 32'(3'b011));

        // Reset in the middle of a pixel burst
        ram[0] = rec(100, 50, 2'b01, 1'b1, 1'b0);
        clear_mon();
        @(negedge clock);
        bus.quantity = 4'd1;
        bus.start    = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        check("mid_plot", 32'(bus.plot), 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_plot",  32'(bus.plot), 0);
        check("rst_flag",  32'(bus.draw_stone_flag), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_x",     32'(bus.x), 0);
        check("rst_y",     32'(bus.y), 0);
        check("rst_col",   32'(bus.colour), 0);
        reset = 1'b0;
        clear_mon();
        repeat (20) @(negedge clock);
        check("post_rst_plots", plot_cnt, 0);
        check("post_rst_busy",  32'(bus.busy), 0);
        $display("reset mid-pixel: plots after release=%0d", plot_cnt);

        // Second start and quantity change while busy must be ignored
        clear_mon();
        @(negedge clock);
        bus.quantity = 4'd1;
        bus.start    = 1'b1;
        cyc = 1;
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 2;
        while (cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        bus.start    = 1'b1;
        bus.quantity = 4'd5;
        @(negedge clock);
        cyc++;
        bus.start = 1'b0;
        while (!bus.done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check("restart_latency", cyc, 262);
        repeat (300) @(negedge clock);
        check("restart_done", done_cnt, 1);
        check("restart_plots", plot_cnt, 256);
        check("restart_idle", 32'(bus.busy), 0);
        $display("second start: done_cycle=%0d done_pulses=%0d plots=%0d", cyc, done_cnt, plot_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stone_drawer.md
STONE_DRAWER -- requirements
Module: stone_drawer

Interface
REQ-001 Parameter STONE_SIZE, default 16, edge length in pixels of the square drawn per stone (power of two, 2..16).
REQ-002 Parameter COL_STONE, default 3'b111, colour for type 2'b00.
REQ-003 Parameter COL_GOLD, default 3'b110, colour for type 2'b01.
REQ-004 Parameter COL_DIAMOND, default 3'b011, colour for types 2'b10 and 2'b11.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to draw all stones for the current frame.
REQ-008 quantity  input  4  number of stone records to scan (indices 0..quantity-1).
REQ-009 data  input  32  stone record from the stone RAM read port, valid one cycle after draw_index is presented; fields X=[31:23], Y=[18:11], type=[3:2], visible=[1], moving=[0].
REQ-010 draw_stone_flag  output  1  high while this block owns the stone RAM read address.
REQ-011 draw_index  output  4  stone RAM read address.
REQ-012 x  output  10  pixel column to plot.
REQ-013 y  output  10  pixel row to plot.
REQ-014 colour  output  3  pixel colour.
REQ-015 plot  output  1  pixel write strobe; x, y, colour valid when high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a frame's scan completes.

Function
REQ-018 FSM states: IDLE, ADDR, WAIT, LATCH, PIXEL, NEXT, DONE; all outputs registered.
REQ-019 IDLE: start=1 -> index counter i<=0; go to DONE if quantity==0, else ADDR; start while busy is ignored.
REQ-020 ADDR: draw_index=i, draw_stone_flag=1 -> WAIT.
REQ-021 WAIT: hold draw_index -> LATCH (one-cycle RAM latency).
REQ-022 LATCH: capture data into an internal record; visible==1 -> PIXEL with row=col=0; visible==0 -> NEXT; moving bit is not used for filtering (a moving stone is still drawn).
REQ-023 PIXEL: each cycle output x={1'b0,X}+col, y={2'b0,Y}+row (zero-extended, no wrap), colour by type, plot=1; col increments fastest, row increments when col wraps from STONE_SIZE-1 to 0; after row=col=STONE_SIZE-1 -> NEXT; exactly STONE_SIZE^2 cycles per visible stone.
REQ-024 Clipping: plot SHALL be 0 for any PIXEL cycle with x>319 or y>239; the pixel cycle is still consumed.
REQ-025 NEXT: plot=0; if i==quantity-1 -> DONE, else i<=i+1 -> ADDR.
REQ-026 DONE: done=1 for exactly one cycle, draw_stone_flag=0 -> IDLE.
REQ-027 draw_stone_flag SHALL be 1 continuously from ADDR of index 0 through the last NEXT, and 0 in IDLE and DONE.
REQ-028 quantity is sampled at start and held for the frame; changes mid-scan have no effect.
REQ-029 Per-frame latency from start: 1 + sum over stones (4 + visible*STONE_SIZE^2) + 1 cycles to done pulse (quantity>0).
REQ-030 plot is 0 in every state other than PIXEL.

Reset
REQ-031 reset=1 at any clock edge, including mid-PIXEL: next state IDLE; draw_stone_flag, draw_index, x, y, colour, plot, busy, done all 0.
REQ-032 After reset deassertion, no pixel is plotted until a new start pulse.

Verification
REQ-033 quantity=0, start -> no plot, draw_stone_flag never high, done pulses on cycle 2 after start.
REQ-034 quantity=1, record X=100,Y=50,type=01,visible=1 -> 256 plot cycles, first (100,50), last (115,65), colour 3'b110, done after 262 cycles.
REQ-035 quantity=3, index 1 visible=0, others visible -> draw_index sequence 0,1,2, 512 plot cycles total, no pixels for index 1.
REQ-036 record X=310,Y=230 visible -> plot high only for x<=319 and y<=239 (100 pixels), still 256 PIXEL cycles.
REQ-037 reset asserted mid-PIXEL of stone 0 -> next cycle plot=0, draw_stone_flag=0, busy=0; start ignored while busy confirmed by second start pulse mid-scan producing no extra done.
